// File: rtl/t_ff_counter_if.sv
// Control/status bundle for t_ff_counter: load/count controls in, count and flags out.
interface t_ff_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, d,
        input  q, t_vec, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, d,
        output q, t_vec, tc, wrap
    );
endinterface

// File: rtl/t_ff_counter.sv
// Up/down modulo counter built from WIDTH T flip-flop stages driven by a toggle-vector generator.
// Define T_CNT_SAT_EN to saturate at terminal count instead of wrapping (wrap is then tied low).
module t_ff_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    t_ff_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] q_p0;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] ld_val;
    logic             q_oor;
    logic             d_oor;
    logic             at_term;
    logic             tc;
    logic             wrap_p1;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v, input logic over);
        return over ? MAX_Q : v;
    endfunction

    function automatic logic [WIDTH-1:0] up_toggles(input logic [WIDTH-1:0] v);
        logic             carry;
        logic [WIDTH-1:0] t;
        carry = 1'b1;
        t     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & v[i];
        end
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] down_toggles(input logic [WIDTH-1:0] v);
        logic             borrow;
        logic [WIDTH-1:0] t;
        borrow = 1'b1;
        t      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]   = borrow;
            borrow = borrow & ~v[i];
        end
        return t;
    endfunction

    // Range checks exist only when MODULO leaves unused codes; otherwise they are constant 0.
    generate
        if (MODULO < (2 ** WIDTH)) begin : g_partial_range
            assign q_oor = (q_p0 > MAX_Q);
            assign d_oor = (bus.d > MAX_Q);
        end else begin : g_full_range
            assign q_oor = 1'b0;
            assign d_oor = 1'b0;
        end
    endgenerate

    assign ld_val = clamp_load(bus.d, d_oor);

    always_comb begin
        at_term = bus.up_dn ? (q_p0 == MAX_Q) : (q_p0 == '0);
        tc      = bus.en & ~bus.load & at_term;
    end

    always_comb begin
        t_vec = '0;
        if (bus.load) begin
            t_vec = q_p0 ^ ld_val;
        end else if (bus.en) begin
            if (q_p0 > MAX_Q || q_oor) begin
                // Recovery from an illegal code: up lands on 0, down lands on MAX_Q.
                t_vec = bus.up_dn ? q_p0 : (q_p0 ^ MAX_Q);
            end else if (at_term) begin
`ifdef T_CNT_SAT_EN
                t_vec = '0;
`else
                t_vec = bus.up_dn ? q_p0 : (q_p0 ^ MAX_Q);
`endif
            end else begin
                t_vec = bus.up_dn ? up_toggles(q_p0) : down_toggles(q_p0);
            end
        end
    end

    // Stage p0: one T flip-flop per bit; every state change is a toggle.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_tff
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_p0[i] <= 1'b0;
                end else begin
                    q_p0[i] <= q_p0[i] ^ t_vec[i];
                end
            end
        end
    endgenerate

    // Stage p1: wrap flags the cycle following a wrapping edge.
`ifdef T_CNT_SAT_EN
    assign wrap_p1 = 1'b0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_p1 <= 1'b0;
        end else begin
            wrap_p1 <= tc;
        end
    end
`endif

    assign bus.q     = q_p0;
    assign bus.t_vec = t_vec;
    assign bus.tc    = tc;
    assign bus.wrap  = wrap_p1;
endmodule

// File: tb/tb_t_ff_counter.sv
// Scoreboard bench for t_ff_counter (WIDTH=4, MODULO=10); expectations follow T_CNT_SAT_EN.
module tb_t_ff_counter;
    typedef struct {
        logic [3:0] q;
        logic [3:0] t;
        logic       tc;
        logic       w;
        string      name;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    exp_t cur;
    int   vectors;
    int   miscompares;

    t_ff_counter_if #(.WIDTH(4)) bus ();

    t_ff_counter #(.WIDTH(4), .MODULO(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s actual=%b required=%b", nm, fld, act, exp);
        end
    endtask

    // Drive inputs just after the edge; the expectation covers outputs for the rest of that cycle.
    task automatic step(input logic rn, input logic e, input logic u, input logic l,
                        input logic [3:0] dv, input logic [3:0] eq, input logic [3:0] et,
                        input logic etc, input logic ew, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = rn;
        bus.en    = e;
        bus.up_dn = u;
        bus.load  = l;
        bus.d     = dv;
        x.q = eq; x.t = et; x.tc = etc; x.w = ew; x.name = nm;
        sb.push_back(x);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                vectors++;
                chk(cur.name, "q",     bus.q,            cur.q);
                chk(cur.name, "t_vec", bus.t_vec,        cur.t);
                chk(cur.name, "tc",    {3'b0, bus.tc},   {3'b0, cur.tc});
                chk(cur.name, "wrap",  {3'b0, bus.wrap}, {3'b0, cur.w});
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.up_dn   = 1'b1;
        bus.load    = 1'b0;
        bus.d       = 4'd0;

        //   rn en up ld d    q  t_vec   tc wrap
        step(0, 1, 1, 0, 0,   0, 4'b0001, 0, 0, "rst_a");
        step(0, 1, 1, 0, 0,   0, 4'b0001, 0, 0, "rst_b");
        step(1, 1, 1, 0, 0,   0, 4'b0001, 0, 0, "rst_rel");
        step(1, 1, 1, 0, 0,   1, 4'b0011, 0, 0, "cnt_1");
        step(1, 1, 1, 0, 0,   2, 4'b0001, 0, 0, "cnt_2");
        step(1, 0, 1, 1, 7,   3, 4'b0100, 0, 0, "ld_7");
        step(1, 0, 1, 0, 0,   7, 4'b0000, 0, 0, "hold_7");
        step(0, 0, 1, 0, 0,   0, 4'b0000, 0, 0, "async_rst");
        step(1, 0, 1, 0, 0,   0, 4'b0000, 0, 0, "rst_rel2");
        step(1, 1, 1, 0, 0,   0, 4'b0001, 0, 0, "up_0");
        step(1, 1, 1, 0, 0,   1, 4'b0011, 0, 0, "up_1");
        step(1, 1, 1, 0, 0,   2, 4'b0001, 0, 0, "up_2");
        step(1, 1, 1, 0, 0,   3, 4'b0111, 0, 0, "up_3");
        step(1, 1, 1, 0, 0,   4, 4'b0001, 0, 0, "up_4");
        step(1, 1, 1, 0, 0,   5, 4'b0011, 0, 0, "up_5");
        step(1, 1, 1, 0, 0,   6, 4'b0001, 0, 0, "up_6");
        step(1, 1, 1, 0, 0,   7, 4'b1111, 0, 0, "up_7");
        step(1, 1, 1, 0, 0,   8, 4'b0001, 0, 0, "up_8");
`ifndef T_CNT_SAT_EN
        step(1, 1, 1, 0, 0,   9, 4'b1001, 1, 0, "up_term");
        step(1, 1, 1, 0, 0,   0, 4'b0001, 0, 1, "up_wrap");
        step(1, 1, 1, 0, 0,   1, 4'b0011, 0, 0, "up_after");
        step(1, 0, 1, 1, 1,   2, 4'b0011, 0, 0, "ld_1");
        step(1, 1, 0, 0, 0,   1, 4'b0001, 0, 0, "dn_1");
        step(1, 1, 0, 0, 0,   0, 4'b1001, 1, 0, "dn_term");
        step(1, 1, 0, 0, 0,   9, 4'b0001, 0, 1, "dn_wrap");
        step(1, 1, 0, 0, 0,   8, 4'b1111, 0, 0, "dn_8");
        step(1, 1, 0, 1, 5,   7, 4'b0010, 0, 0, "ld_pri");
`else
        step(1, 1, 1, 0, 0,   9, 4'b0000, 1, 0, "sat_up_a");
        step(1, 1, 1, 0, 0,   9, 4'b0000, 1, 0, "sat_up_b");
        step(1, 1, 1, 0, 0,   9, 4'b0000, 1, 0, "sat_up_c");
        step(1, 0, 1, 1, 1,   9, 4'b1000, 0, 0, "ld_1");
        step(1, 1, 0, 0, 0,   1, 4'b0001, 0, 0, "dn_1");
        step(1, 1, 0, 0, 0,   0, 4'b0000, 1, 0, "sat_dn_a");
        step(1, 1, 0, 0, 0,   0, 4'b0000, 1, 0, "sat_dn_b");
        step(1, 1, 0, 0, 0,   0, 4'b0000, 1, 0, "sat_dn_c");
        step(1, 1, 0, 1, 5,   0, 4'b0101, 0, 0, "ld_pri");
`endif
        step(1, 1, 0, 1, 13,  5, 4'b1100, 0, 0, "ld_clamp");
        step(1, 0, 0, 0, 0,   9, 4'b0000, 0, 0, "hold_a");
        step(1, 0, 0, 0, 0,   9, 4'b0000, 0, 0, "hold_b");
        step(1, 0, 0, 0, 0,   9, 4'b0000, 0, 0, "hold_c");
        step(1, 1, 1, 1, 5,   9, 4'b1100, 0, 0, "ld_over_tc");
        step(1, 0, 1, 1, 4,   5, 4'b0001, 0, 0, "ld_4");
        step(1, 1, 1, 0, 0,   4, 4'b0001, 0, 0, "dir_up");
        step(1, 1, 0, 0, 0,   5, 4'b0001, 0, 0, "dir_dn");
        step(1, 1, 1, 0, 0,   4, 4'b0001, 0, 0, "dir_up2");
        step(1, 1, 0, 0, 0,   5, 4'b0001, 0, 0, "dir_dn2");
        step(1, 0, 0, 0, 0,   4, 4'b0000, 0, 0, "dir_end");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
